// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the CPU datapath (master) and the multiply/divide unit (slave).
// Carries the start/op request, MTHI/MTLO writes, the busy stall and the HI/LO results.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; WIDTH+1 cycles from accepted start to result.
// No queueing: start is honoured only in IDLE, busy stalls the CPU for the whole operation.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk_in,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_res, neg_rem, div_zero;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   a_raw;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               sgn, sa, sb, last_iter;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd;

  assign sgn       = ~bus.op[0];
  assign sa        = sgn & bus.a[WIDTH-1];
  assign sb        = sgn & bus.b[WIDTH-1];
  assign mag_a     = sa ? -bus.a : bus.a;
  assign mag_b     = sb ? -bus.b : bus.b;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // Multiply: acc low half starts as the multiplier and is shifted out LSB-first.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : {(WIDTH+1){1'b0}});
  // Divide: acc low half holds the dividend, quotient bits shift in from the right.
  assign rem_sh   = {rem, acc[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, divisor};

  // Most-negative / -1 needs no special case: magnitude 2^(W-1) negates back onto itself.
  assign prod = neg_res ? -acc : acc;
  assign quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rmd  = neg_rem ? -rem : rem;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      rem      <= '0;
      divisor  <= '0;
      a_raw    <= '0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_div   <= bus.op[1];
            neg_res  <= sa ^ sb;
            neg_rem  <= sa;
            div_zero <= bus.op[1] && (bus.b == '0);
            a_raw    <= bus.a;
            divisor  <= mag_b;
            acc      <= {{WIDTH{1'b0}}, mag_a};
            rem      <= '0;
            cnt      <= '0;
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!rem_diff[WIDTH]) begin
              rem            <= rem_diff[WIDTH-1:0];
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b1};
            end else begin
              rem            <= rem_sh[WIDTH-1:0];
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIN: begin
          done_q <= 1'b1;
          if (!is_div) begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
          end else if (div_zero) begin
            hi_q <= a_raw;
            lo_q <= '1;
          end else begin
            hi_q <= rmd;
            lo_q <= quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against a 64-bit arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  muldiv_unit_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.clk_in(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference: plain wide arithmetic; returns {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return ux * uy;
      2'd2: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge in IDLE; returns at the negedge right after the accepting edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (bus.busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_tests++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    n_tests++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult_signed();
    int lat, bc;
    launch(2'd0, 32'hFFFFFFFD, 32'd5);
    wait_done(lat, bc);
    n_tests++; if (lat != 33) begin n_fail++; $display("FAIL mult_latency: got %0d want 33", lat); end
    n_tests++; if (bc != 33) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_at_done: got %b want 0", bus.busy); end
    n_tests++; if (bus.hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
    n_tests++; if (bus.lo !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_lo: got %h want fffffff1", bus.lo); end
    @(negedge clk);
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    launch(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bc);
    n_tests++; if (bus.hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
    n_tests++; if (bus.lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
    launch(2'd2, 32'hFFFFFFF9, 32'd2);
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy got %b want 1", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_low: got %b want 0", bus.done); end
    wait_done(lat, bc);
    n_tests++; if (lat != 33) begin n_fail++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    n_tests++; if (bus.lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", bus.lo); end
    n_tests++; if (bus.hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", bus.hi); end
    @(negedge clk);
  endtask

  task automatic test_div_corner();
    int lat, bc;
    launch(2'd3, 32'd7, 32'd0);
    wait_done(lat, bc);
    n_tests++; if (lat != 33) begin n_fail++; $display("FAIL divz_latency: got %0d want 33", lat); end
    n_tests++; if (bus.lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divuz_lo: got %h want ffffffff", bus.lo); end
    n_tests++; if (bus.hi !== 32'd7) begin n_fail++; $display("FAIL divuz_hi: got %h want 00000007", bus.hi); end
    @(negedge clk);
    launch(2'd2, 32'hFFFFFFFB, 32'd0);
    wait_done(lat, bc);
    n_tests++; if (bus.lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divz_lo: got %h want ffffffff", bus.lo); end
    n_tests++; if (bus.hi !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL divz_hi: got %h want fffffffb", bus.hi); end
    @(negedge clk);
    launch(2'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bc);
    n_tests++; if (bus.lo !== 32'h80000000) begin n_fail++; $display("FAIL divovf_lo: got %h want 80000000", bus.lo); end
    n_tests++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL divovf_hi: got %h want 0", bus.hi); end
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    int lat, bc;
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    n_tests++; if (bus.hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_idle: got %h want 00001234", bus.hi); end
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5678;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    n_tests++; if ({bus.hi, bus.lo} !== {32'h5678, 32'h5678}) begin n_fail++; $display("FAIL mthi_mtlo_both: got %h_%h want 00005678_00005678", bus.hi, bus.lo); end
    launch(2'd0, 32'd2, 32'd3);
    bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
    @(negedge clk);
    bus.hi_we = 1'b0;
    n_tests++; if (bus.hi !== 32'h5678) begin n_fail++; $display("FAIL mthi_busy_dropped: got %h want 00005678", bus.hi); end
    wait_done(lat, bc);
    n_tests++; if ({bus.hi, bus.lo} !== {32'd0, 32'd6}) begin n_fail++; $display("FAIL mult_2x3: got %h_%h want 00000000_00000006", bus.hi, bus.lo); end
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'h55;
    @(negedge clk);
    bus.wdata = 32'hABCD;
    launch(2'd1, 32'd1, 32'd1);
    bus.hi_we = 1'b0;
    n_tests++; if (bus.hi !== 32'h55) begin n_fail++; $display("FAIL mthi_with_start_dropped: got %h want 00000055", bus.hi); end
    wait_done(lat, bc);
    n_tests++; if ({bus.hi, bus.lo} !== {32'd0, 32'd1}) begin n_fail++; $display("FAIL multu_1x1: got %h_%h want 00000000_00000001", bus.hi, bus.lo); end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int lat, bc, extra;
    launch(2'd3, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'hFFFF; bus.b = 32'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bc);
    n_tests++; if (lat + 5 != 33) begin n_fail++; $display("FAIL ignore_start_latency: got %0d want 33", lat + 5); end
    n_tests++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_100_7: got %h_%h want 00000002_0000000e", bus.hi, bus.lo); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL ignore_start_no_second_op: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    launch(2'd0, 32'h01234567, 32'h89);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done: got %b want 0", bus.done); end
    n_tests++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL async_reset_hi: got %h want 0", bus.hi); end
    n_tests++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL async_reset_lo: got %h want 0", bus.lo); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(2'd0, 32'd6, 32'd7);
    wait_done(lat, bc);
    n_tests++; if (lat != 33) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 33", lat); end
    n_tests++; if ({bus.hi, bus.lo} !== {32'd0, 32'd42}) begin n_fail++; $display("FAIL post_reset_6x7: got %h_%h want 00000000_0000002a", bus.hi, bus.lo); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bc;
    logic [1:0]  o;
    logic [31:0] x, y, wv;
    logic [63:0] e;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        wv = $urandom;
        bus.lo_we = 1'b1; bus.wdata = wv;
        @(negedge clk);
        bus.lo_we = 1'b0;
        n_tests++; if (bus.lo !== wv) begin n_fail++; $display("FAIL rand_mtlo[%0d]: got %h want %h", i, bus.lo, wv); end
      end
      o = 2'($urandom_range(0, 3));
      x = pick();
      y = pick();
      e = model(o, x, y);
      launch(o, x, y);
      wait_done(lat, bc);
      n_tests++; if (lat != 33 || bc != 33) begin n_fail++; $display("FAIL rand_timing[%0d]: got lat=%0d busy=%0d want 33/33", i, lat, bc); end
      n_tests++; if ({bus.hi, bus.lo} !== e) begin n_fail++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h_%h want %h_%h", i, o, x, y, bus.hi, bus.lo, e[63:32], e[31:0]); end
      if (i[0]) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    test_reset();
    test_mult_signed();
    test_back_to_back();
    test_div_corner();
    test_mthi_mtlo();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "timeout");
  end
endmodule
